bp_trace_enc: RTL and testbench



---
 rtl/bp_trace_enc_pkg.sv | 51 +++++
 rtl/bp_trace_enc_fifo.sv | 60 ++++++
 rtl/bp_trace_enc.sv | 116 +++++++++++
 tb/tb_bp_trace_enc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_trace_enc_pkg.sv
// bp_trace_enc_pkg
//   Shared types and constants for the commit-stream trace encoder.
//   - trace_type_e    : 2-bit word type (SYNC, INSTR, SYNC_LOST)
//   - commit_fields_s : view of the 102-bit commit packet (pc, instr, pad)
//   - trace_word_s    : 64-bit trace word (type, seq, 56-bit payload)
//   - make_word()     : builds a trace word from type/seq/pc/instr
package bp_trace_enc_pkg;

    localparam int VADDR_W  = 40;
    localparam int INSTR_W  = 32;
    localparam int TRACE_W  = 64;
    localparam int SEQ_W    = 6;
    localparam int PAD_W    = 30;
    localparam int COMMIT_W = VADDR_W + INSTR_W + PAD_W;
    localparam int PAYLD_W  = TRACE_W - 2 - SEQ_W;

    typedef enum logic [1:0] {
        TR_SYNC      = 2'b01,
        TR_INSTR     = 2'b10,
        TR_SYNC_LOST = 2'b11
    } trace_type_e;

    typedef struct packed {
        logic [VADDR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
        logic [PAD_W-1:0]   pad;
    } commit_fields_s;

    typedef struct packed {
        trace_type_e        ttype;
        logic [SEQ_W-1:0]   seq;
        logic [PAYLD_W-1:0] payload;
    } trace_word_s;

    // INSTR carries the full instruction; both SYNC flavours carry the
    // low instruction half-word plus the full PC.
    function automatic trace_word_s make_word(input trace_type_e        t,
                                              input logic [SEQ_W-1:0]   seq,
                                              input logic [VADDR_W-1:0] pc,
                                              input logic [INSTR_W-1:0] instr);
        trace_word_s w;
        w.ttype = t;
        w.seq   = seq;
        if (t == TR_INSTR)
            w.payload = {{(PAYLD_W-INSTR_W){1'b0}}, instr};
        else
            w.payload = {instr[15:0], pc};
        return w;
    endfunction

endpackage

// File: rtl/bp_trace_enc_fifo.sv
// bp_trace_enc_fifo
//   Small circular FIFO with a valid/ready read side.
//   clk_i, reset_i (async, active high)
//   data_i/v_i  : write data / push request (taken if not full or popping)
//   full_o      : all els_p slots occupied
//   data_o/v_o  : head word / non-empty; when empty data_o keeps showing the
//                 most recently popped word
//   ready_i     : sink ready; pop on v_o & ready_i
module bp_trace_enc_fifo #(
    parameter int els_p   = 4,
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               full_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               ready_i
);

    localparam int PTR_W = $clog2(els_p);
    localparam int CNT_W = PTR_W + 1;

    logic [els_p-1:0][width_p-1:0] mem;
    logic [PTR_W-1:0]              wr_ptr, rd_ptr, prev_rd;
    logic [CNT_W-1:0]              count;
    logic                          push, pop;

    assign v_o     = (count != '0);
    assign full_o  = (count == CNT_W'(els_p));
    assign pop     = v_o & ready_i;
    assign push    = v_i & (~full_o | pop);
    // Slot behind rd_ptr is the last popped word; it cannot be overwritten
    // while the FIFO is empty because the next write lands on rd_ptr.
    assign prev_rd = rd_ptr - 1'b1;
    assign data_o  = v_o ? mem[rd_ptr] : mem[prev_rd];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bp_trace_enc.sv
// bp_trace_enc
//   Commit-stream trace encoder. Every accepted commit (commit_v_i &
//   commit_ready_i) becomes one 64-bit trace word, buffered in a FIFO and
//   drained over trace_data_o / trace_v_o / trace_ready_i.
//   clk_i, reset_i (async, active high)
//   commit_pkt_i   : [101:62] pc, [61:30] instr, [29:0] ignored
//   commit_v_i     : packet valid
//   commit_ready_i : backend ready (observed only)
//   trace_data_o   : FIFO head word
//   trace_v_o      : FIFO non-empty
//   trace_ready_i  : sink ready
// Build option BP_TRACE_ENC_COMPRESS_EN: when defined, straight-line commits
//   are emitted as compact INSTR words (with a SYNC forced after
//   sync_period_p of them); when undefined every stored commit is a SYNC or
//   SYNC_LOST word.
module bp_trace_enc
    import bp_trace_enc_pkg::*;
#(
    parameter int fifo_els_p    = 4,
    parameter int sync_period_p = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [COMMIT_W-1:0] commit_pkt_i,
    input  logic                commit_v_i,
    input  logic                commit_ready_i,
    output logic [TRACE_W-1:0]  trace_data_o,
    output logic                trace_v_o,
    input  logic                trace_ready_i
);

    commit_fields_s     cf;
    trace_word_s        word;
    trace_type_e        wtype;
    logic               accept, pop, drop, store, fifo_full, is_seq;
    logic [SEQ_W-1:0]   seq_q;
    logic [VADDR_W-1:0] last_pc_q;
    logic               last_valid_q, lost_q;
    logic               unused_pad;

    assign cf         = commit_fields_s'(commit_pkt_i);
    assign unused_pad = ^cf.pad;

    assign accept = commit_v_i & commit_ready_i;
    assign pop    = trace_v_o & trace_ready_i;
    // A pop in the same cycle frees a slot, so only full-without-pop drops.
    assign drop   = accept & fifo_full & ~pop;
    assign store  = accept & ~drop;

`ifdef BP_TRACE_ENC_COMPRESS_EN
    localparam int RUN_W = $clog2(sync_period_p + 1);
    logic [RUN_W-1:0] run_q;

    assign is_seq = last_valid_q && !lost_q
                 && (cf.pc == last_pc_q + VADDR_W'(4))
                 && (run_q < RUN_W'(sync_period_p));

    // Run of consecutive INSTR words since the last SYNC-type word.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            run_q <= '0;
        else if (store)
            run_q <= is_seq ? run_q + 1'b1 : '0;
    end
`else
    logic unused_period;
    assign is_seq        = 1'b0;
    assign unused_period = ^32'(sync_period_p);
`endif

    always_comb begin
        wtype = TR_SYNC;
        if (lost_q)
            wtype = TR_SYNC_LOST;
        else if (is_seq)
            wtype = TR_INSTR;
    end

    assign word = make_word(wtype, seq_q, cf.pc, cf.instr);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            seq_q        <= '0;
            last_pc_q    <= '0;
            last_valid_q <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            // seq counts every accepted commit so drops show up as gaps.
            if (accept)
                seq_q <= seq_q + 1'b1;
            if (drop) begin
                lost_q       <= 1'b1;
                last_valid_q <= 1'b0;
            end else if (store) begin
                lost_q       <= 1'b0;
                last_valid_q <= 1'b1;
                last_pc_q    <= cf.pc;
            end
        end
    end

    bp_trace_enc_fifo #(
        .els_p   (fifo_els_p),
        .width_p (TRACE_W)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (word),
        .v_i     (store),
        .full_o  (fifo_full),
        .data_o  (trace_data_o),
        .v_o     (trace_v_o),
        .ready_i (trace_ready_i)
    );

endmodule

// File: tb/tb_bp_trace_enc.sv
// tb_bp_trace_enc
//   Randomized and directed stimulus for bp_trace_enc, checked every cycle
//   against a queue-based reference model, plus literal expected words.
//   Honours BP_TRACE_ENC_COMPRESS_EN the same way as the design.
module tb_bp_trace_enc;

    localparam int FIFO_ELS    = 4;
    localparam int SYNC_PERIOD = 64;
`ifdef BP_TRACE_ENC_COMPRESS_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [101:0] pkt = '0;
    logic         cv = 1'b0, cr = 1'b0, tr = 1'b0;
    logic [63:0]  tdata;
    logic         tv;

    int total = 0, bad = 0;

    bp_trace_enc #(.fifo_els_p(FIFO_ELS), .sync_period_p(SYNC_PERIOD)) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .commit_pkt_i   (pkt),
        .commit_v_i     (cv),
        .commit_ready_i (cr),
        .trace_data_o   (tdata),
        .trace_v_o      (tv),
        .trace_ready_i  (tr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] q[$];
    logic [63:0] held = '0;
    logic [39:0] m_last_pc = '0;
    bit          m_lv = 0, m_lost = 0;
    int          m_run = 0, m_seq = 0;

    function automatic logic [63:0] mk(input logic [1:0] t, input int seq,
                                       input logic [39:0] pc, input logic [31:0] ins);
        logic [5:0] s;
        s = 6'(seq % 64);
        if (t == 2'b10) return {t, s, 24'h0, ins};
        return {t, s, ins[15:0], pc};
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete(); held = '0; m_last_pc = '0;
            m_lv = 0; m_lost = 0; m_run = 0; m_seq = 0;
        end else begin
            bit          pop, full, acc, seqn;
            logic [39:0] pc;
            logic [31:0] ins;
            logic [1:0]  t;
            full = (q.size() == FIFO_ELS);
            pop  = (q.size() != 0) && tr;
            acc  = cv && cr;
            pc   = pkt[101:62];
            ins  = pkt[61:30];
            if (pop) held = q.pop_front();
            if (acc) begin
                if (full && !pop) begin
                    m_lost = 1; m_lv = 0;
                end else begin
                    seqn = COMP && m_lv && !m_lost && (pc == m_last_pc + 40'd4)
                           && (m_run < SYNC_PERIOD);
                    t = m_lost ? 2'b11 : (seqn ? 2'b10 : 2'b01);
                    q.push_back(mk(t, m_seq, pc, ins));
                    m_run = seqn ? m_run + 1 : 0;
                    m_lost = 0; m_lv = 1; m_last_pc = pc;
                end
                m_seq = (m_seq + 1) % 64;
            end
        end
    end

    // per-cycle compare, plus capture of words handed to the sink
    logic [63:0] obs[$];
    bit          obs_en = 0;
    initial forever begin
        @(negedge clk);
        check("valid", {63'd0, tv}, {63'd0, q.size() != 0});
        check("data", tdata, (q.size() != 0) ? q[0] : held);
        if (obs_en && tv && tr) obs.push_back(tdata);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        cv = 0; cr = 0; tr = 0; rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    task automatic commit(input logic [39:0] pc, input logic [31:0] ins);
        pkt = {pc, ins, 30'($urandom)}; cv = 1; cr = 1;
        tick();
        cv = 0;
    endtask

    task automatic pop1();
        tr = 1; tick(); tr = 0;
    endtask

    initial begin
        logic [63:0] e;
        logic [1:0]  t;
        logic [39:0] rpc, npc;

        tick();
        check("reset_v", {63'd0, tv}, 64'd0);
        check("reset_data", tdata, 64'd0);
        do_reset();

        // first word and the compressed / uncompressed follower
        commit(40'h1000, 32'h13);
        check("first_v", {63'd0, tv}, 64'd1);
        check("first_word", tdata, 64'h4000_1300_0000_1000);
        commit(40'h1004, 32'h13);
        pop1();
        e = COMP ? 64'h8100_0000_0000_0013 : 64'h4100_1300_0000_1004;
        check("second_word", tdata, e);
        pop1();
        check("empty_v", {63'd0, tv}, 64'd0);
        check("empty_hold", tdata, e);

        // non-sequential jump
        do_reset();
        commit(40'h1000, 32'h13);
        commit(40'h2000, 32'h13);
        pop1();
        check("jump_sync", tdata, 64'h4100_1300_0000_2000);
        pop1(); pop1();

        // overflow: fifth commit dropped, next stored is SYNC_LOST seq 5
        do_reset();
        for (int i = 0; i < FIFO_ELS + 1; i++) commit(40'h1000 + 40'(4 * i), 32'h13);
        pop1();
        commit(40'h1000 + 40'(4 * (FIFO_ELS + 1)), 32'h13);
        for (int i = 0; i < FIFO_ELS - 1; i++) pop1();
        check("lost_v", {63'd0, tv}, 64'd1);
        check("lost_word", tdata, 64'hC500_1300_0000_1014);
        pop1();

        // long straight-line run: forced SYNC and seq wrap
        do_reset();
        obs.delete(); obs_en = 1; tr = 1;
        for (int i = 0; i < 66; i++) begin
            pkt = {40'h8000 + 40'(4 * i), 32'h13, 30'd0}; cv = 1; cr = 1;
            tick();
        end
        cv = 0;
        tick(); tick(); tick();
        obs_en = 0; tr = 0;
        check("run_count", 64'(obs.size()), 64'd66);
        if (obs.size() >= 66) begin
            check("run_w0_type", 64'(obs[0][63:62]), 64'd1);
            t = COMP ? 2'b10 : 2'b01;
            check("run_w64_type", 64'(obs[64][63:62]), 64'(t));
            check("run_w64_seq", 64'(obs[64][61:56]), 64'd0);
            check("run_w65_type", 64'(obs[65][63:62]), 64'd1);
            check("run_w65_seq", 64'(obs[65][61:56]), 64'd1);
        end

        // async reset with words queued
        do_reset();
        commit(40'h1000, 32'h13); commit(40'h1004, 32'h13); commit(40'h1008, 32'h13);
        #2 rst = 1;
        #1;
        check("async_v", {63'd0, tv}, 64'd0);
        check("async_data", tdata, 64'd0);
        tick();
        rst = 0;
        commit(40'h3000, 32'h13);
        check("post_reset_word", tdata, 64'h4000_1300_0000_3000);

        // randomized traffic
        do_reset();
        rpc = 40'h4000;
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 9))
                0: npc = {8'($urandom), $urandom};
                1: npc = 40'hFF_FFFF_FFF8;
                default: npc = rpc + 40'd4;
            endcase
            pkt = {npc, $urandom, 30'($urandom)};
            cv  = ($urandom_range(0, 9) < 7);
            cr  = ($urandom_range(0, 9) < 8);
            tr  = ($urandom_range(0, 9) < 5);
            if (cv && cr) rpc = npc;
            tick();
        end
        cv = 0; tr = 1;
        for (int i = 0; i < FIFO_ELS + 2; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
